// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-side PC owner: imem req/ready fetch, one-entry skid, IF/ID register,
// redirect squash and HALT handling.
module fetch_pc_unit #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_addr,
  input  logic             halt,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_data,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc_plus2,
  output logic             flush_out,
  output logic             halted
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD, S_HALT} state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic             req_q, req_d, flush_q, flush_d, halted_q, halted_d;
  logic             halt_pend_q, halt_pend_d;
  logic             ifv_q, ifv_d;
  logic [WIDTH-1:0] instr_q, instr_d, ifpc_q, ifpc_d, ifpc2_q, ifpc2_d;
  logic             skv_q, skv_d;
  logic [WIDTH-1:0] skinstr_q, skinstr_d, skpc_q, skpc_d;

  logic             take_redirect, halt_now, deliver, go_req;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc        = pc_q + STEP;
  assign take_redirect = redirect_valid && (state_q != S_HALT);
  assign halt_now      = halt && !stall && !redirect_valid;
  assign deliver       = (state_q == S_REQ) && imem_ready && !take_redirect && !halt_now;
  // Issue decision looks at the IF/ID and skid contents as they will be after this edge.
  assign go_req        = !skv_d && (!ifv_d || !stall) && !halt;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    halt_pend_d = halt_pend_q;
    ifv_d       = ifv_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    ifpc2_d     = ifpc2_q;
    skv_d       = skv_q;
    skinstr_d   = skinstr_q;
    skpc_d      = skpc_q;

    if (state_q == S_HALT) begin
      ifv_d = 1'b0;
    end else if (take_redirect) begin
      ifv_d = 1'b0;
      skv_d = 1'b0;
    end else if (deliver && (!stall || !ifv_q)) begin
      ifv_d   = 1'b1;
      instr_d = imem_data;
      ifpc_d  = pc_q;
      ifpc2_d = pc_inc;
    end else if (deliver) begin
      skv_d     = 1'b1;
      skinstr_d = imem_data;
      skpc_d    = pc_q;
    end else if (skv_q && !stall) begin
      ifv_d   = 1'b1;
      instr_d = skinstr_q;
      ifpc_d  = skpc_q;
      ifpc2_d = skpc_q + STEP;
      skv_d   = 1'b0;
    end else if (!stall) begin
      ifv_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (take_redirect) begin
          pc_d    = redirect_addr;
          addr_d  = redirect_addr;
          state_d = S_REQ;
        end else if (halt_now) begin
          state_d = S_HALT;
        end else if (go_req) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (take_redirect) begin
          pc_d = redirect_addr;
          if (imem_ready) begin
            addr_d = redirect_addr;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (halt_now) begin
            state_d = S_HALT;
          end else if (go_req) begin
            addr_d = pc_inc;
          end else begin
            state_d = S_IDLE;
          end
        end else if (halt_now) begin
          halt_pend_d = 1'b1;
          state_d     = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The old request stays on the bus untouched; only its returned word is thrown away.
        if (take_redirect) begin
          pc_d        = redirect_addr;
          halt_pend_d = 1'b0;
        end else if (halt_now) begin
          halt_pend_d = 1'b1;
        end
        if (imem_ready) begin
          if (halt_pend_d) begin
            halt_pend_d = 1'b0;
            state_d     = S_HALT;
          end else begin
            addr_d  = pc_d;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_HALT;
    endcase

    req_d    = (state_d == S_REQ) || (state_d == S_DISCARD);
    flush_d  = take_redirect;
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      ifv_q       <= 1'b0;
      instr_q     <= '0;
      ifpc_q      <= '0;
      ifpc2_q     <= '0;
      skv_q       <= 1'b0;
      skinstr_q   <= '0;
      skpc_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      flush_q     <= flush_d;
      halted_q    <= halted_d;
      halt_pend_q <= halt_pend_d;
      ifv_q       <= ifv_d;
      instr_q     <= instr_d;
      ifpc_q      <= ifpc_d;
      ifpc2_q     <= ifpc2_d;
      skv_q       <= skv_d;
      skinstr_q   <= skinstr_d;
      skpc_q      <= skpc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = ifv_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus2 = ifpc2_q;
  assign flush_out   = flush_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed vector table, wrap/async-reset sequence and a random
// stream run checked against a program-order fetch model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, halt, imem_ready;
  logic [15:0] redirect_addr, imem_data;
  logic        imem_req, if_valid, flush_out, halted;
  logic [15:0] imem_addr, if_instr, if_pc, if_pc_plus2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .flush_out(flush_out), .halted(halted)
  );

  typedef struct {
    logic        st, rv;
    logic [15:0] ra;
    logic        hl, rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_ifv;
    logic [15:0] e_ifpc;
    logic        e_fl, e_hal;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic st, input logic rv, input logic [15:0] ra,
                              input logic hl, input logic rdy, input logic e_req,
                              input logic [15:0] e_addr, input logic e_ifv,
                              input logic [15:0] e_ifpc, input logic e_fl, input logic e_hal);
    vec_t v;
    v.st = st; v.rv = rv; v.ra = ra; v.hl = hl; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_ifpc = e_ifpc;
    v.e_fl = e_fl; v.e_hal = e_hal;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Memory model: the word at an address is addr ^ A5A5.
  task automatic drive(input logic st, input logic rv, input logic [15:0] ra,
                       input logic hl, input logic rdy);
    stall = st; redirect_valid = rv; redirect_addr = ra; halt = hl; imem_ready = rdy;
    imem_data = imem_addr ^ 16'hA5A5;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, 16'(imem_req), 16'h0);
    check({tag, "_addr"}, imem_addr, 16'h0000);
    check({tag, "_ifv"}, 16'(if_valid), 16'h0);
    check({tag, "_instr"}, if_instr, 16'h0000);
    check({tag, "_ifpc"}, if_pc, 16'h0000);
    check({tag, "_ifpc2"}, if_pc_plus2, 16'h0000);
    check({tag, "_flush"}, 16'(flush_out), 16'h0);
    check({tag, "_halted"}, 16'(halted), 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_pc, wait_addr, ra;
    logic        st, rv, rdy, wait_req;
    int          consumed;

    // Stream, wait states, stall/skid, redirect during wait, redirect vs halt.
    for (int a = 0; a < 9; a++)
      vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'(2 * a), a != 0, 16'(2 * a - 2), 0, 0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0010, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0012, 1, 16'h0010, 0, 0));
    for (int i = 0; i < 4; i++) vt.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 16'h0010, 0, 0));
    for (int a = 0; a < 7; a++)
      vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'(16'h0014 + 2 * a), 1, 16'(16'h0012 + 2 * a), 0, 0));
    vt.push_back(mk(0, 1, 16'h0100, 0, 0, 1, 16'h0020, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0020, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0100, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0102, 1, 16'h0100, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0104, 1, 16'h0102, 0, 0));
    vt.push_back(mk(0, 1, 16'h0200, 1, 1, 1, 16'h0200, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0202, 1, 16'h0200, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0204, 1, 16'h0202, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 16'h0204, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 16'h0300, 0, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0);
    tick();
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].st, vt[i].rv, vt[i].ra, vt[i].hl, vt[i].rdy);
      tick();
      check($sformatf("v%0d_req", i), 16'(imem_req), 16'(vt[i].e_req));
      if (vt[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("v%0d_ifv", i), 16'(if_valid), 16'(vt[i].e_ifv));
      if (vt[i].e_ifv) begin
        check($sformatf("v%0d_ifpc", i), if_pc, vt[i].e_ifpc);
        check($sformatf("v%0d_instr", i), if_instr, vt[i].e_ifpc ^ 16'hA5A5);
        check($sformatf("v%0d_ifpc2", i), if_pc_plus2, vt[i].e_ifpc + 16'h0002);
      end
      check($sformatf("v%0d_flush", i), 16'(flush_out), 16'(vt[i].e_fl));
      check($sformatf("v%0d_halted", i), 16'(halted), 16'(vt[i].e_hal));
    end

    // Address wrap, then asynchronous reset in the middle of a waiting request.
    do_reset();
    drive(0, 1, 16'hFFFC, 0, 1);
    tick();
    check("wrap_addr_fffc", imem_addr, 16'hFFFC);
    check("wrap_flush", 16'(flush_out), 16'h1);
    drive(0, 0, 0, 0, 1);
    tick();
    check("wrap_addr_fffe", imem_addr, 16'hFFFE);
    drive(0, 0, 0, 0, 1);
    tick();
    check("wrap_addr_0000", imem_addr, 16'h0000);
    check("wrap_ifpc", if_pc, 16'hFFFE);
    check("wrap_ifpc2", if_pc_plus2, 16'h0000);
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    check("pre_rst_req", 16'(imem_req), 16'h1);
    check("pre_rst_addr", imem_addr, 16'h0004);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    tick();
    check("post_rst_req", 16'(imem_req), 16'h1);
    check("post_rst_addr", imem_addr, 16'h0000);

    // Random stream: every consumed instruction must follow program order from the last redirect.
    do_reset();
    exp_pc   = 16'h0000;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      ra  = 16'($urandom) & 16'hFFFE;
      drive(st, rv, ra, 0, rdy);
      if (if_valid && !st && !rv) begin
        check("rnd_ifpc", if_pc, exp_pc);
        check("rnd_instr", if_instr, exp_pc ^ 16'hA5A5);
        check("rnd_ifpc2", if_pc_plus2, exp_pc + 16'h0002);
        exp_pc = exp_pc + 16'h0002;
        consumed++;
      end
      if (rv) exp_pc = ra;
      wait_req  = imem_req && !rdy;
      wait_addr = imem_addr;
      tick();
      check("rnd_flush", 16'(flush_out), 16'(rv));
      if (wait_req) begin
        check("rnd_req_held", 16'(imem_req), 16'h1);
        check("rnd_addr_held", imem_addr, wait_addr);
      end
    end
    check("rnd_progress", 16'(consumed > 300), 16'h1);
    check("rnd_not_halted", 16'(halted), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
